// File: rtl/eth_rx_pkg.sv
// Shared constants, FSM encoding and the CRC-32 byte step for the RMII receiver.
package eth_rx_pkg;

  localparam int          pMII_WIDTH = 2;
  localparam logic [1:0]  PRE_DIBIT  = 2'b01;
  localparam logic [1:0]  SFD_DIBIT  = 2'b11;
  localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // The wire carries bits LSB-first, so the shift register runs in reflected form.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic [31:0] p;
    p = reflect32(CRC_POLY);
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ p) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_crc.sv
// CRC-32 accumulator: one byte per i_valid, restarted by i_clr; o_crc is the complemented result.
module eth_rx_crc
  import eth_rx_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;
  logic [31:0] w_next;

  always_comb w_next = crc32_byte(r_crc, i_byte);

  always_ff @(posedge Clk) begin
    if (Rst || i_clr) begin
      r_crc <= CRC_INIT;
    end else if (i_valid) begin
      r_crc <= w_next;
    end
  end

  assign o_crc = r_crc ^ CRC_XOROUT;

endmodule

// File: rtl/eth_rx.sv
// RMII receive path: preamble/SFD qualification, LSB-first byte assembly, and
// per-frame CRC, alignment and length status reported three clocks after carrier drop.
module eth_rx
  import eth_rx_pkg::*;
#(
  parameter int pMin_Preamble = 8,
  parameter int pMin_Len      = 64,
  parameter int pMax_Len      = 1518
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [pMII_WIDTH-1:0] Rxd,
  input  logic                  Crs_Dv,
  output logic [7:0]            Rx_Byte,
  output logic                  Rx_Byte_Valid,
  output logic                  Rx_Sof,
  output logic                  Rx_Done,
  output logic                  Rx_Crc_Err,
  output logic                  Rx_Align_Err,
  output logic                  Rx_Len_Err,
  output logic [10:0]           Rx_Len
);

  localparam logic [10:0] LEN_SAT = 11'd2047;
  localparam logic [10:0] MIN_LEN = 11'(pMin_Len);
  localparam logic [10:0] MAX_LEN = 11'(pMax_Len);
  localparam logic [7:0]  MIN_PRE = 8'(pMin_Preamble);

  rx_state_e             r_state;
  logic [pMII_WIDTH-1:0] r_rxd;
  logic                  r_crs_dv;
  logic [7:0]            r_byte;
  logic [1:0]            r_dibit_cnt;
  logic [7:0]            r_pre_cnt;
  logic [10:0]           r_len;
  logic [31:0]           r_fcs;
  logic                  r_sof_seen;
  logic                  r_end1;
  logic                  r_end2;

  logic [7:0]  w_byte;
  logic [10:0] w_len_inc;
  logic [7:0]  w_pre_base;
  logic        w_sfd;
  logic        w_counting;
  logic        w_byte_done;
  logic        w_crc_valid;
  logic [31:0] w_crc;

  // The first dibit of a burst is judged in IDLE itself, so it counts toward the preamble.
  always_comb begin
    w_byte      = {r_rxd, r_byte[7:2]};
    w_len_inc   = (r_len == LEN_SAT) ? LEN_SAT : r_len + 11'd1;
    w_pre_base  = (r_state == ST_IDLE) ? 8'd0 : r_pre_cnt;
    w_sfd       = r_crs_dv && ((r_state == ST_IDLE) || (r_state == ST_PREAMBLE)) &&
                  (r_rxd == SFD_DIBIT) && (w_pre_base >= MIN_PRE);
    w_counting  = r_crs_dv && ((r_state == ST_DATA) || ((r_state == ST_DROP) && r_sof_seen));
    w_byte_done = w_counting && (r_dibit_cnt == 2'd3);
    w_crc_valid = w_byte_done && (r_len >= 11'd4);
  end

  // Bytes leaving the 4-byte FCS delay line are the ones folded into the CRC.
  eth_rx_crc u_crc (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_clr   (w_sfd),
    .i_valid (w_crc_valid),
    .i_byte  (r_fcs[7:0]),
    .o_crc   (w_crc)
  );

  assign Rx_Byte = r_byte;

  // Input register, receive FSM, byte assembly and the end-of-frame status pipeline.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= ST_IDLE;
      r_rxd         <= '0;
      r_crs_dv      <= 1'b0;
      r_byte        <= 8'd0;
      r_dibit_cnt   <= 2'd0;
      r_pre_cnt     <= 8'd0;
      r_len         <= 11'd0;
      r_fcs         <= 32'd0;
      r_sof_seen    <= 1'b0;
      r_end1        <= 1'b0;
      r_end2        <= 1'b0;
      Rx_Byte_Valid <= 1'b0;
      Rx_Sof        <= 1'b0;
      Rx_Done       <= 1'b0;
      Rx_Crc_Err    <= 1'b0;
      Rx_Align_Err  <= 1'b0;
      Rx_Len_Err    <= 1'b0;
      Rx_Len        <= 11'd0;
    end else begin
      r_rxd         <= Rxd;
      r_crs_dv      <= Crs_Dv;
      Rx_Byte_Valid <= 1'b0;
      Rx_Sof        <= 1'b0;
      r_end1        <= 1'b0;
      r_end2        <= r_end1;
      Rx_Done       <= r_end2;
      if (r_end2) begin
        Rx_Len       <= r_len;
        Rx_Align_Err <= (r_dibit_cnt != 2'd0);
        Rx_Len_Err   <= (r_len < MIN_LEN) || (r_len > MAX_LEN);
        Rx_Crc_Err   <= (r_len < 11'd4) || (w_crc != r_fcs);
      end
      case (r_state)
        ST_IDLE, ST_PREAMBLE: begin
          r_sof_seen <= 1'b0;
          if (!r_crs_dv) begin
            r_state   <= ST_IDLE;
            r_pre_cnt <= 8'd0;
          end else if (r_rxd == PRE_DIBIT) begin
            r_state   <= ST_PREAMBLE;
            r_pre_cnt <= (w_pre_base == 8'hFF) ? 8'hFF : w_pre_base + 8'd1;
          end else if (w_sfd) begin
            r_state     <= ST_DATA;
            r_dibit_cnt <= 2'd0;
            r_len       <= 11'd0;
            r_fcs       <= 32'd0;
          end else if ((r_rxd == 2'b00) && (w_pre_base == 8'd0)) begin
            r_state <= ST_PREAMBLE;
          end else begin
            r_state <= ST_DROP;
          end
        end
        ST_DATA, ST_DROP: begin
          if (!r_crs_dv) begin
            r_state <= ST_IDLE;
            r_end1  <= r_sof_seen;
          end else if (w_counting) begin
            r_byte      <= w_byte;
            r_dibit_cnt <= r_dibit_cnt + 2'd1;
            if (w_byte_done) begin
              r_len <= w_len_inc;
              r_fcs <= {w_byte, r_fcs[31:8]};
              if ((r_state == ST_DATA) && (w_len_inc == MAX_LEN + 11'd1)) begin
                r_state <= ST_DROP;
              end else if (r_state == ST_DATA) begin
                Rx_Byte_Valid <= 1'b1;
                Rx_Sof        <= (r_len == 11'd0);
                r_sof_seen    <= 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx.sv
// Directed bench for eth_rx: frames built from byte lists, expectations from a bit-serial CRC model.
module tb_eth_rx;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [1:0]  Rxd;
  logic        Crs_Dv;
  logic [7:0]  Rx_Byte;
  logic        Rx_Byte_Valid, Rx_Sof, Rx_Done, Rx_Crc_Err, Rx_Align_Err, Rx_Len_Err;
  logic [10:0] Rx_Len;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  typedef struct {
    int len;
    bit crc_err;
    bit align_err;
    bit len_err;
    bit chk_crc;
    int done_cyc;
  } done_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         n_valid = 0;
  int         base = 0;
  bit         chk_en = 1'b0;
  logic [8:0] exp_bytes[$];
  done_t      exp_done[$];
  logic [7:0] fr[$];
  logic [8:0] cmp_e;
  done_t      cmp_d;

  eth_rx dut (
    .Clk(Clk), .Rst(Rst), .Rxd(Rxd), .Crs_Dv(Crs_Dv),
    .Rx_Byte(Rx_Byte), .Rx_Byte_Valid(Rx_Byte_Valid), .Rx_Sof(Rx_Sof), .Rx_Done(Rx_Done),
    .Rx_Crc_Err(Rx_Crc_Err), .Rx_Align_Err(Rx_Align_Err), .Rx_Len_Err(Rx_Len_Err), .Rx_Len(Rx_Len)
  );

  always #10 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_crc(input logic [7:0] b[$], input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++)
        c = (c[0] ^ b[i][k]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return ~c;
  endfunction

  function automatic bit fcs_ok(input int n);
    if (n < 4) return 1'b0;
    return model_crc(fr, n - 4) == {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
  endfunction

  task automatic append_fcs();
    logic [31:0] c;
    c = model_crc(fr, fr.size());
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
    fr.push_back(c[23:16]);
    fr.push_back(c[31:24]);
  endtask

  task automatic build_min();
    fr.delete();
    for (int i = 0; i < 6; i++) fr.push_back(8'hFF);
    for (int i = 0; i < 6; i++) fr.push_back(8'h00);
    fr.push_back(8'h08);
    fr.push_back(8'h00);
    for (int i = 0; i < 46; i++) fr.push_back(8'h00);
    append_fcs();
  endtask

  task automatic build_pat(input int n_data, input int mul, input int add);
    fr.delete();
    for (int i = 0; i < n_data; i++) fr.push_back(8'((i * mul + add) & 255));
    append_fcs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, Rx_Byte_Valid, 0);
    check({tag, "_sof"}, Rx_Sof, 0);
    check({tag, "_done"}, Rx_Done, 0);
    check({tag, "_byte"}, Rx_Byte, 0);
    check({tag, "_crc_err"}, Rx_Crc_Err, 0);
    check({tag, "_align_err"}, Rx_Align_Err, 0);
    check({tag, "_len_err"}, Rx_Len_Err, 0);
    check({tag, "_len"}, Rx_Len, 0);
  endtask

  // n_emit < 0 lets the model decide how many bytes must stream out.
  task automatic send_frame(input int pre_n, input int extra, input int rst_at, input int n_emit,
                            input bit want_done, input bit chk_crc, input int gap);
    logic [1:0] dq[$];
    logic [7:0] b;
    done_t      d;
    int         n;
    int         ne;
    n  = fr.size();
    ne = (n_emit < 0) ? ((n < MAX_LEN) ? n : MAX_LEN) : n_emit;
    for (int i = 0; i < ne; i++) exp_bytes.push_back({(i == 0) ? 1'b1 : 1'b0, fr[i]});
    for (int i = 0; i < pre_n; i++) dq.push_back(2'b01);
    dq.push_back(2'b11);
    for (int i = 0; i < n; i++) begin
      b = fr[i];
      for (int k = 0; k < 4; k++) dq.push_back(b[2*k +: 2]);
    end
    for (int i = 0; i < extra; i++) dq.push_back(2'b10);
    for (int i = 0; i < dq.size(); i++) begin
      Rxd    = dq[i];
      Crs_Dv = 1'b1;
      Rst    = (i == rst_at);
      @(posedge Clk); #1;
      if (i == rst_at) check_all_zero("mid_reset");
    end
    Rst    = 1'b0;
    Crs_Dv = 1'b0;
    Rxd    = 2'b00;
    @(posedge Clk); #1;
    if (want_done) begin
      d.len       = (n > 2047) ? 2047 : n;
      d.crc_err   = !fcs_ok(n);
      d.align_err = (extra % 4) != 0;
      d.len_err   = (n < MIN_LEN) || (n > MAX_LEN);
      d.chk_crc   = chk_crc;
      d.done_cyc  = cyc + 3;
      exp_done.push_back(d);
    end
    repeat (gap - 1) begin
      @(posedge Clk); #1;
    end
  endtask

  // Scoreboard compare on the falling edge, away from the sampling edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      if (Rx_Byte_Valid === 1'b1) begin
        n_valid++;
        check("byte_expected", exp_bytes.size() != 0, 1);
        if (exp_bytes.size() != 0) begin
          cmp_e = exp_bytes.pop_front();
          check("rx_byte", Rx_Byte, cmp_e[7:0]);
          check("rx_sof", Rx_Sof, cmp_e[8]);
        end
      end else begin
        check("sof_without_valid", Rx_Sof, 0);
      end
      if (Rx_Done === 1'b1) begin
        check("done_expected", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) begin
          cmp_d = exp_done.pop_front();
          check("done_cycle", cyc, cmp_d.done_cyc);
          check("rx_len", Rx_Len, cmp_d.len);
          check("len_err", Rx_Len_Err, cmp_d.len_err);
          check("align_err", Rx_Align_Err, cmp_d.align_err);
          if (cmp_d.chk_crc) check("crc_err", Rx_Crc_Err, cmp_d.crc_err);
        end
      end
    end
  end

  initial begin
    Rst    = 1'b1;
    Rxd    = 2'b00;
    Crs_Dv = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_all_zero("reset");
    Rst    = 1'b0;
    chk_en = 1'b1;

    fr.delete();
    for (int i = 0; i < 9; i++) fr.push_back(8'(8'h31 + i));
    check("model_crc_123456789", model_crc(fr, 9), 32'hCBF4_3926);
    repeat (4) begin
      @(posedge Clk); #1;
    end

    build_min();
    base = n_valid;
    send_frame(8, 0, -1, -1, 1'b1, 1'b1, 12);
    check("min_frame_bytes", n_valid - base, 64);

    build_min();
    fr[30] = fr[30] ^ 8'h01;
    check("model_flip_detects", fcs_ok(fr.size()), 0);
    send_frame(8, 0, -1, -1, 1'b1, 1'b1, 12);

    build_min();
    base = n_valid;
    send_frame(8, 1, -1, -1, 1'b1, 1'b1, 12);
    check("extra_dibit_bytes", n_valid - base, 64);

    build_min();
    base = n_valid;
    send_frame(5, 0, -1, 0, 1'b0, 1'b0, 1);
    check("short_preamble_bytes", n_valid - base, 0);
    build_min();
    base = n_valid;
    send_frame(8, 0, -1, -1, 1'b1, 1'b1, 12);
    check("after_drop_bytes", n_valid - base, 64);

    build_pat(1514, 7, 3);
    send_frame(8, 0, -1, -1, 1'b1, 1'b1, 12);

    build_pat(1596, 13, 5);
    base = n_valid;
    send_frame(8, 0, -1, -1, 1'b1, 1'b0, 12);
    check("oversize_bytes", n_valid - base, 1518);

    build_pat(36, 3, 1);
    send_frame(8, 0, -1, -1, 1'b1, 1'b1, 12);

    fr.delete();
    fr.push_back(8'hAA);
    fr.push_back(8'h55);
    send_frame(8, 0, -1, -1, 1'b1, 1'b1, 12);

    build_pat(56, 1, 0);
    base = n_valid;
    send_frame(8, 0, 90, 20, 1'b0, 1'b0, 12);
    check("reset_frame_bytes", n_valid - base, 20);
    build_min();
    base = n_valid;
    send_frame(8, 0, -1, -1, 1'b1, 1'b1, 12);
    check("post_reset_bytes", n_valid - base, 64);

    repeat (20) begin
      @(posedge Clk); #1;
    end
    check("bytes_left", exp_bytes.size(), 0);
    check("dones_left", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
